// File: rtl/sa_autosa_ssa_sync_evt_rx.sv
// Destination-side event receiver for a toggle synchronizer.
// Each level toggle becomes one queued event, presented on a valid/ready handshake.
module sa_autosa_ssa_sync_evt_rx #(
  parameter int CNT_W    = 4,
  parameter int TOT_W    = 16,
  parameter int INIT_CYC = 4
) (
  input  logic             o_clk,
  input  logic             o_rst,
  input  logic             sync_q,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_pending,
  output logic             evt_ovf,
  input  logic             ovf_clr,
  output logic [TOT_W-1:0] evt_total,
  output logic             armed
);

  localparam int IW = (INIT_CYC > 1) ? $clog2(INIT_CYC + 1) : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;
  logic             sq_q, sq_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [TOT_W-1:0] tot_q, tot_d;

  logic edge_w;
  logic acc_w;

  // The baseline level is always refreshed so the first RUN cycle compares
  // against the level seen at the end of INIT, never against reset.
  assign edge_w = (state_q == ST_RUN) & (sync_q ^ sq_q);
  assign acc_w  = (state_q == ST_RUN) & valid_q & evt_ready;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    sq_d       = sync_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    tot_d      = tot_q;
    unique case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ovf_clr) begin
          ovf_d = 1'b0;
        end
        if (edge_w) begin
          tot_d = tot_q + 1'b1;
        end
        unique case ({edge_w, acc_w})
          2'b10: begin
            if (pend_q != CNT_MAX) begin
              pend_d = pend_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          2'b01:   pend_d = pend_q - 1'b1;
          default: pend_d = pend_q;
        endcase
      end
      default: state_d = ST_INIT;
    endcase
    valid_d = (pend_d != '0);
  end

  always_ff @(posedge o_clk) begin
    if (o_rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      sq_q       <= 1'b0;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      tot_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      sq_q       <= sq_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      tot_q      <= tot_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_pending = pend_q;
  assign evt_ovf     = ovf_q;
  assign evt_total   = tot_q;
  assign armed       = (state_q == ST_RUN);

endmodule

// File: tb/tb_sa_autosa_ssa_sync_evt_rx.sv
// Directed vector bench for sa_autosa_ssa_sync_evt_rx.
// Small counters (CNT_W=2, TOT_W=4) expose saturation and wrap quickly.
module tb_sa_autosa_ssa_sync_evt_rx;

  localparam int CNT_W = 2;
  localparam int TOT_W = 4;
  localparam int INIT_CYC = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             sq;
  logic             rdy;
  logic             clr;
  logic             v;
  logic [CNT_W-1:0] p;
  logic             ovf;
  logic [TOT_W-1:0] tot;
  logic             arm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sa_autosa_ssa_sync_evt_rx #(
    .CNT_W(CNT_W),
    .TOT_W(TOT_W),
    .INIT_CYC(INIT_CYC)
  ) dut (
    .o_clk(clk),
    .o_rst(rst),
    .sync_q(sq),
    .evt_valid(v),
    .evt_ready(rdy),
    .evt_pending(p),
    .evt_ovf(ovf),
    .ovf_clr(clr),
    .evt_total(tot),
    .armed(arm)
  );

  typedef struct {
    logic       rst;
    logic       sq;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [1:0] p;
    logic       ovf;
    logic [3:0] tot;
    logic       arm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic rd, logic c,
                              logic ev, int ep, logic eo, int et,
                              logic ea);
    vec_t x;
    x.rst = r;
    x.sq  = s;
    x.rdy = rd;
    x.clr = c;
    x.v   = ev;
    x.p   = 2'(ep);
    x.ovf = eo;
    x.tot = 4'(et);
    x.arm = ea;
    return x;
  endfunction

  task automatic chk(string nm, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(int idx, vec_t x);
    chk("valid", idx, int'(v), int'(x.v));
    chk("pending", idx, int'(p), int'(x.p));
    chk("ovf", idx, int'(ovf), int'(x.ovf));
    chk("total", idx, int'(tot), int'(x.tot));
    chk("armed", idx, int'(arm), int'(x.arm));
  endtask

  initial begin
    logic s;
    rst = 1'b1;
    sq  = 1'b0;
    rdy = 1'b0;
    clr = 1'b0;

    //            rst sq rdy clr | v p ovf tot arm
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 0, 2, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 3, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 2, 0, 3, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 3, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 5, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3, 0, 6, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 1, 7, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 3, 0, 7, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 3, 0, 8, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 3, 1, 9, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 3, 0, 9, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 3, 0, 10, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 2, 0, 10, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 11, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3, 1, 12, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 2, 1, 12, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      sq  = tbl[i].sq;
      rdy = tbl[i].rdy;
      clr = tbl[i].clr;
      step();
      check_all(i, tbl[i]);
    end

    // Total counter wraps; accept-with-toggle keeps pending at 1.
    s = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s   = ~s;
      sq  = s;
      rdy = 1'b1;
      step();
      chk("wrap_total", 100 + i, int'(tot), i % 16);
      chk("wrap_pend", 100 + i, int'(p), 1);
    end

    // Drain the last event, then ready stays ignored at zero.
    step();
    chk("drain_pend", 200, int'(p), 0);
    chk("drain_valid", 200, int'(v), 0);
    step();
    chk("idle_pend", 201, int'(p), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
